// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two operand sources, the consumer and alu_arbiter.
// The master side drives requests and RespReady; the slave side is the arbiter.
interface alu_arbiter_if;
  logic       ReqValidA;
  logic       ReqValidB;
  logic       ReqReadyA;
  logic       ReqReadyB;
  logic [3:0] Num1A;
  logic [3:0] Num2A;
  logic [3:0] Num1B;
  logic [3:0] Num2B;
  logic       MA;
  logic       MB;
  logic       RespValid;
  logic       RespReady;
  logic       RespId;
  logic [3:0] Result;
  logic       SF;
  logic       ZF;
  logic       CF;
  logic       OF;
  logic [7:0] OpCount;

  modport master (
    output ReqValidA, ReqValidB, Num1A, Num2A, Num1B, Num2B, MA, MB, RespReady,
    input  ReqReadyA, ReqReadyB, RespValid, RespId, Result, SF, ZF, CF, OF, OpCount
  );

  modport slave (
    input  ReqValidA, ReqValidB, Num1A, Num2A, Num1B, Num2B, MA, MB, RespReady,
    output ReqReadyA, ReqReadyB, RespValid, RespId, Result, SF, ZF, CF, OF, OpCount
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 4-bit add/sub ALU between requesters A and B,
// with registered operands, a fixed execute cycle and a held, ID-tagged response.
module alu_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic       r_last_grant;
  logic       w_any;
  logic       w_grant;

  logic [3:0] r_num1;
  logic [3:0] r_num2;
  logic       r_m;
  logic       r_id;

  logic [3:0] r_result;
  logic       r_sf;
  logic       r_zf;
  logic       r_cf;
  logic       r_of;
  logic       r_resp_valid;
  logic       r_resp_id;
  logic [7:0] r_op_count;
  logic [7:0] w_alu;

  // Returns {result[3:0], SF, ZF, CF, OF}; carry into bit 3 is recovered from the sum bit.
  function automatic logic [7:0] alu_addsub(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic       m);
    logic [3:0] b_eff;
    logic [4:0] full;
    logic       c2;
    logic       c3;
    b_eff = m ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {4'b0000, m};
    c3    = full[4];
    c2    = full[3] ^ a[3] ^ b_eff[3];
    return {full[3:0], full[3], (full[3:0] == 4'd0), c3 ^ m, c3 ^ c2};
  endfunction

  assign w_alu = alu_addsub(r_num1, r_num2, r_m);

  always_comb begin
    w_any   = bus.ReqValidA | bus.ReqValidB;
    w_grant = bus.ReqValidB;
    if (bus.ReqValidA && bus.ReqValidB) begin
      w_grant = ~r_last_grant;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_any) w_next = EXEC;
      EXEC:    w_next = RESP;
      RESP:    if (bus.RespReady) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request stage: capture the granted requester's operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_num1       <= 4'd0;
      r_num2       <= 4'd0;
      r_m          <= 1'b0;
      r_id         <= 1'b0;
    end else if (r_state == IDLE && w_any) begin
      r_last_grant <= w_grant;
      r_id         <= w_grant;
      r_num1       <= w_grant ? bus.Num1B : bus.Num1A;
      r_num2       <= w_grant ? bus.Num2B : bus.Num2A;
      r_m          <= w_grant ? bus.MB    : bus.MA;
    end
  end

  // Execute stage: latch ALU result and flags, then hold them until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result     <= 4'd0;
      r_sf         <= 1'b0;
      r_zf         <= 1'b0;
      r_cf         <= 1'b0;
      r_of         <= 1'b0;
      r_resp_id    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_op_count   <= 8'd0;
    end else begin
      if (r_state == EXEC) begin
        {r_result, r_sf, r_zf, r_cf, r_of} <= w_alu;
        r_resp_id    <= r_id;
        r_resp_valid <= 1'b1;
      end else if (r_state == RESP && bus.RespReady) begin
        r_resp_valid <= 1'b0;
        r_op_count   <= r_op_count + 8'd1;
      end
    end
  end

  assign bus.ReqReadyA = (r_state == IDLE) && w_any && !w_grant;
  assign bus.ReqReadyB = (r_state == IDLE) && w_any &&  w_grant;
  assign bus.RespValid = r_resp_valid;
  assign bus.RespId    = r_resp_id;
  assign bus.Result    = r_result;
  assign bus.SF        = r_sf;
  assign bus.ZF        = r_zf;
  assign bus.CF        = r_cf;
  assign bus.OF        = r_of;
  assign bus.OpCount   = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: arithmetic/flag vectors, round-robin order,
// response back-pressure, reset during execute and OpCount wrap.
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_arbiter_if bus();

  alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic       id;
    logic [3:0] n1;
    logic [3:0] n2;
    logic       m;
    logic [3:0] res;
    logic [3:0] f;   // {SF, ZF, CF, OF}
  } vec_t;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ReqValidA = 1'b0; bus.ReqValidB = 1'b0;
    bus.Num1A = 4'd0; bus.Num2A = 4'd0; bus.MA = 1'b0;
    bus.Num1B = 4'd0; bus.Num2B = 4'd0; bus.MB = 1'b0;
    bus.RespReady = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Issues one request and returns at the first negedge where RespValid is seen.
  task automatic run_op(input logic id, input logic [3:0] n1, input logic [3:0] n2,
                        input logic m, output logic ok, output int lat);
    int k;
    ok = 1'b0;
    lat = 0;
    @(negedge clk);
    if (!id) begin
      bus.ReqValidA = 1'b1; bus.Num1A = n1; bus.Num2A = n2; bus.MA = m;
    end else begin
      bus.ReqValidB = 1'b1; bus.Num1B = n1; bus.Num2B = n2; bus.MB = m;
    end
    #1;
    for (k = 0; k < 20; k++) begin
      if ((!id && bus.ReqReadyA) || (id && bus.ReqReadyB)) break;
      @(negedge clk); #1;
    end
    if (k == 20) begin
      bus.ReqValidA = 1'b0; bus.ReqValidB = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (!id) bus.ReqValidA = 1'b0; else bus.ReqValidB = 1'b0;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      lat++;
      if (bus.RespValid) break;
    end
    ok = bus.RespValid;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_total++; if (bus.RespValid !== 1'b0) $display("FAIL reset RespValid: got %b want 0", bus.RespValid); else n_pass++;
    n_total++; if (bus.RespId !== 1'b0) $display("FAIL reset RespId: got %b want 0", bus.RespId); else n_pass++;
    n_total++; if (bus.Result !== 4'd0) $display("FAIL reset Result: got %h want 0", bus.Result); else n_pass++;
    n_total++; if ({bus.SF, bus.ZF, bus.CF, bus.OF} !== 4'b0000) $display("FAIL reset flags: got %b want 0000", {bus.SF, bus.ZF, bus.CF, bus.OF}); else n_pass++;
    n_total++; if (bus.OpCount !== 8'd0) $display("FAIL reset OpCount: got %0d want 0", bus.OpCount); else n_pass++;
  endtask

  task automatic test_arith();
    vec_t vecs[5];
    logic ok;
    int   lat;
    vecs[0] = '{id:1'b0, n1:4'd7,  n2:4'd1, m:1'b0, res:4'b1000, f:4'b1001};
    vecs[1] = '{id:1'b1, n1:4'd3,  n2:4'd3, m:1'b1, res:4'b0000, f:4'b0100};
    vecs[2] = '{id:1'b1, n1:4'd2,  n2:4'd5, m:1'b1, res:4'b1101, f:4'b1010};
    vecs[3] = '{id:1'b0, n1:4'd15, n2:4'd1, m:1'b0, res:4'b0000, f:4'b0110};
    vecs[4] = '{id:1'b0, n1:4'd8,  n2:4'd1, m:1'b1, res:4'b0111, f:4'b0001};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].id, vecs[i].n1, vecs[i].n2, vecs[i].m, ok, lat);
      n_total++; if (ok !== 1'b1) $display("FAIL arith%0d response: got %b want 1", i, ok); else n_pass++;
      n_total++; if (lat != 2) $display("FAIL arith%0d latency: got %0d want 2", i, lat); else n_pass++;
      n_total++; if (bus.Result !== vecs[i].res) $display("FAIL arith%0d Result: got %b want %b", i, bus.Result, vecs[i].res); else n_pass++;
      n_total++; if ({bus.SF, bus.ZF, bus.CF, bus.OF} !== vecs[i].f) $display("FAIL arith%0d flags SZCO: got %b want %b", i, {bus.SF, bus.ZF, bus.CF, bus.OF}, vecs[i].f); else n_pass++;
      n_total++; if (bus.RespId !== vecs[i].id) $display("FAIL arith%0d RespId: got %b want %b", i, bus.RespId, vecs[i].id); else n_pass++;
      @(posedge clk); #1;
      n_total++; if (bus.OpCount !== 8'(i + 1)) $display("FAIL arith%0d OpCount: got %0d want %0d", i, bus.OpCount, i + 1); else n_pass++;
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.ReqValidA = 1'b1; bus.Num1A = 4'd1; bus.Num2A = 4'd1; bus.MA = 1'b0;
    bus.ReqValidB = 1'b1; bus.Num1B = 4'd2; bus.Num2B = 4'd2; bus.MB = 1'b0;
    #1;
    for (int i = 0; i < 12; i++) begin
      n_total++; if (bus.ReqReadyA !== (i % 6 == 0)) $display("FAIL rr cyc%0d ReqReadyA: got %b want %b", i, bus.ReqReadyA, (i % 6 == 0)); else n_pass++;
      n_total++; if (bus.ReqReadyB !== (i % 6 == 3)) $display("FAIL rr cyc%0d ReqReadyB: got %b want %b", i, bus.ReqReadyB, (i % 6 == 3)); else n_pass++;
      n_total++; if (bus.RespValid !== (i % 3 == 2)) $display("FAIL rr cyc%0d RespValid: got %b want %b", i, bus.RespValid, (i % 3 == 2)); else n_pass++;
      if (i % 3 == 2) begin
        n_total++; if (bus.RespId !== (i % 6 == 5)) $display("FAIL rr cyc%0d RespId: got %b want %b", i, bus.RespId, (i % 6 == 5)); else n_pass++;
        n_total++; if (bus.Result !== ((i % 6 == 5) ? 4'd4 : 4'd2)) $display("FAIL rr cyc%0d Result: got %h want %h", i, bus.Result, ((i % 6 == 5) ? 4'd4 : 4'd2)); else n_pass++;
      end
      @(negedge clk); #1;
    end
    bus.ReqValidA = 1'b0; bus.ReqValidB = 1'b0;
  endtask

  task automatic test_backpressure();
    logic ok;
    int   lat;
    int   k;
    bus.RespReady = 1'b0;
    run_op(1'b0, 4'd5, 4'd6, 1'b0, ok, lat);
    n_total++; if (ok !== 1'b1) $display("FAIL bp response: got %b want 1", ok); else n_pass++;
    bus.ReqValidB = 1'b1; bus.Num1B = 4'd1; bus.Num2B = 4'd1; bus.MB = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 2) begin
        bus.Num1A = 4'hF; bus.Num2B = 4'd1;
      end
      n_total++; if (bus.RespValid !== 1'b1) $display("FAIL bp%0d RespValid: got %b want 1", i, bus.RespValid); else n_pass++;
      n_total++; if (bus.Result !== 4'b1011) $display("FAIL bp%0d Result: got %b want 1011", i, bus.Result); else n_pass++;
      n_total++; if ({bus.SF, bus.ZF, bus.CF, bus.OF} !== 4'b1001) $display("FAIL bp%0d flags SZCO: got %b want 1001", i, {bus.SF, bus.ZF, bus.CF, bus.OF}); else n_pass++;
      n_total++; if (bus.RespId !== 1'b0) $display("FAIL bp%0d RespId: got %b want 0", i, bus.RespId); else n_pass++;
      n_total++; if ({bus.ReqReadyA, bus.ReqReadyB} !== 2'b00) $display("FAIL bp%0d ReqReady: got %b want 00", i, {bus.ReqReadyA, bus.ReqReadyB}); else n_pass++;
    end
    bus.RespReady = 1'b1;
    @(posedge clk); #1;
    n_total++; if (bus.RespValid !== 1'b0) $display("FAIL bp release RespValid: got %b want 0", bus.RespValid); else n_pass++;
    n_total++; if (bus.ReqReadyB !== 1'b1) $display("FAIL bp release ReqReadyB: got %b want 1", bus.ReqReadyB); else n_pass++;
    @(posedge clk); #1;
    bus.ReqValidB = 1'b0;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.RespValid) break;
    end
    n_total++; if (bus.RespValid !== 1'b1) $display("FAIL bp pending response: got %b want 1", bus.RespValid); else n_pass++;
    n_total++; if (bus.Result !== 4'd2) $display("FAIL bp pending Result: got %h want 2", bus.Result); else n_pass++;
    n_total++; if (bus.RespId !== 1'b1) $display("FAIL bp pending RespId: got %b want 1", bus.RespId); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_in_exec();
    logic ok;
    int   lat;
    int   k;
    run_op(1'b0, 4'd7, 4'd1, 1'b0, ok, lat);
    @(posedge clk); #1;
    @(negedge clk);
    bus.ReqValidA = 1'b1; bus.Num1A = 4'd9; bus.Num2A = 4'd9; bus.MA = 1'b0;
    #1;
    for (k = 0; k < 10; k++) begin
      if (bus.ReqReadyA) break;
      @(negedge clk); #1;
    end
    n_total++; if (bus.ReqReadyA !== 1'b1) $display("FAIL rstx grant: got %b want 1", bus.ReqReadyA); else n_pass++;
    @(posedge clk); #1;
    bus.ReqValidA = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.RespValid !== 1'b0) $display("FAIL rstx RespValid: got %b want 0", bus.RespValid); else n_pass++;
    n_total++; if (bus.Result !== 4'd0) $display("FAIL rstx Result: got %h want 0", bus.Result); else n_pass++;
    n_total++; if ({bus.SF, bus.ZF, bus.CF, bus.OF} !== 4'b0000) $display("FAIL rstx flags: got %b want 0000", {bus.SF, bus.ZF, bus.CF, bus.OF}); else n_pass++;
    n_total++; if (bus.OpCount !== 8'd0) $display("FAIL rstx OpCount: got %0d want 0", bus.OpCount); else n_pass++;
    n_total++; if (bus.RespId !== 1'b0) $display("FAIL rstx RespId: got %b want 0", bus.RespId); else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_total++; if (bus.RespValid !== 1'b0) $display("FAIL rstx after%0d RespValid: got %b want 0", i, bus.RespValid); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    logic ok;
    int   lat;
    int   misses;
    misses = 0;
    do_reset();
    for (int i = 0; i < 255; i++) begin
      run_op(i[0], 4'(i), 4'd3, 1'b0, ok, lat);
      if (!ok) misses++;
      @(posedge clk); #1;
    end
    n_total++; if (misses != 0) $display("FAIL wrap responses missing: got %0d want 0", misses); else n_pass++;
    n_total++; if (bus.OpCount !== 8'd255) $display("FAIL wrap OpCount at 255: got %0d want 255", bus.OpCount); else n_pass++;
    run_op(1'b1, 4'd0, 4'd0, 1'b0, ok, lat);
    @(posedge clk); #1;
    n_total++; if (bus.OpCount !== 8'd0) $display("FAIL wrap OpCount at 256: got %0d want 0", bus.OpCount); else n_pass++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    bus.ReqValidA = 1'b0; bus.ReqValidB = 1'b0;
    bus.Num1A = 4'd0; bus.Num2A = 4'd0; bus.MA = 1'b0;
    bus.Num1B = 4'd0; bus.Num2B = 4'd0; bus.MB = 1'b0;
    bus.RespReady = 1'b1;
    test_reset();
    test_arith();
    test_round_robin();
    test_backpressure();
    test_reset_in_exec();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
